// File: rtl/cache_refill_ctrl_v2.sv
// cache_refill_ctrl_v2: shared I/D line refill and dirty write-back engine.
// Streams words over the SPI master word port and gates the core clock.
`timescale 1ns/1ps
module cache_refill_ctrl_v2 #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int LINE_WORDS    = 4,
  parameter int D_FIRST       = 1,
  parameter int BUBBLE_CYCLES = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_miss_req,
  input  logic [ADDR_W-1:0]             i_miss_addr,
  input  logic                          d_miss_req,
  input  logic [ADDR_W-1:0]             d_miss_addr,
  input  logic                          d_victim_dirty,
  input  logic [ADDR_W-1:0]             d_victim_addr,
  input  logic [DATA_W-1:0]             d_victim_data,
  output logic [$clog2(LINE_WORDS)-1:0] victim_idx,
  output logic                          i_refill_we,
  output logic                          d_refill_we,
  output logic [ADDR_W-1:0]             refill_addr,
  output logic [DATA_W-1:0]             refill_data,
  output logic                          i_miss_ack,
  output logic                          d_miss_ack,
  output logic [ADDR_W-1:0]             spi_address,
  output logic [DATA_W-1:0]             spi_store,
  output logic [DATA_W/8-1:0]           write_strobe,
  output logic                          spi_addr_valid,
  input  logic                          spi_ready,
  input  logic [DATA_W-1:0]             spi_fetch,
  output logic                          set_clk_enable,
  output logic                          core_bubble,
  output logic                          busy
);
  localparam int BYTES = DATA_W / 8;
  localparam int WI_W  = $clog2(LINE_WORDS);
  localparam int LB    = $clog2(LINE_WORDS * BYTES);
  localparam int BC_W  = (BUBBLE_CYCLES > 1) ? $clog2(BUBBLE_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] LMASK =
    ~((ADDR_W'(1) << LB) - ADDR_W'(1));

  typedef enum logic [1:0] {IDLE, WB, FILL, BUBBLE} state_t;

  state_t              state_q;
  logic [WI_W-1:0]     wcnt_q;
  logic [BC_W-1:0]     bcnt_q;
  logic                sel_d_q;
  logic                done_q;
  logic [ADDR_W-1:0]   miss_base_q;
  logic [ADDR_W-1:0]   vic_base_q;
  logic [ADDR_W-1:0]   spi_addr_q;
  logic                valid_q;
  logic [BYTES-1:0]    wstrb_q;
  logic                clk_en_q;
  logic                bubble_q;
  logic                i_we_q;
  logic                d_we_q;
  logic [ADDR_W-1:0]   raddr_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                i_ack_q;
  logic                d_ack_q;

  function automatic logic [ADDR_W-1:0] word_addr(
    input logic [ADDR_W-1:0] base,
    input logic [WI_W-1:0]   k
  );
    return base + ADDR_W'(k) * ADDR_W'(BYTES);
  endfunction

  // A slice whose ack is on the wire has not yet dropped its request.
  logic            i_req_m, d_req_m, d_win, fire, last;
  logic [WI_W-1:0] wcnt_nxt;
  logic [ADDR_W-1:0] i_base, d_base, v_base;

  assign i_req_m  = i_miss_req & ~i_ack_q;
  assign d_req_m  = d_miss_req & ~d_ack_q;
  assign d_win    = d_req_m & ((D_FIRST != 0) | ~i_req_m);
  assign fire     = valid_q & spi_ready;
  assign last     = (wcnt_q == WI_W'(LINE_WORDS - 1));
  assign wcnt_nxt = wcnt_q + WI_W'(1);
  assign i_base   = i_miss_addr & LMASK;
  assign d_base   = d_miss_addr & LMASK;
  assign v_base   = d_victim_addr & LMASK;

  // Service sequencer: arbitration, write-back, refill, bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      bcnt_q      <= '0;
      sel_d_q     <= 1'b0;
      done_q      <= 1'b0;
      miss_base_q <= '0;
      vic_base_q  <= '0;
      spi_addr_q  <= '0;
      valid_q     <= 1'b0;
      wstrb_q     <= '0;
      clk_en_q    <= 1'b1;
      bubble_q    <= 1'b0;
      i_we_q      <= 1'b0;
      d_we_q      <= 1'b0;
      raddr_q     <= '0;
      rdata_q     <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
    end else begin
      i_we_q  <= 1'b0;
      d_we_q  <= 1'b0;
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_req_m | d_req_m) begin
            sel_d_q     <= d_win;
            miss_base_q <= d_win ? d_base : i_base;
            vic_base_q  <= v_base;
            wcnt_q      <= '0;
            valid_q     <= 1'b1;
            clk_en_q    <= 1'b0;
            if (d_win & d_victim_dirty) begin
              state_q    <= WB;
              spi_addr_q <= v_base;
              wstrb_q    <= '1;
            end else begin
              state_q    <= FILL;
              spi_addr_q <= d_win ? d_base : i_base;
              wstrb_q    <= '0;
            end
          end
        end
        WB: begin
          if (fire) begin
            wcnt_q <= wcnt_nxt;
            if (last) begin
              state_q    <= FILL;
              spi_addr_q <= miss_base_q;
              wstrb_q    <= '0;
            end else begin
              spi_addr_q <= word_addr(vic_base_q, wcnt_nxt);
            end
          end
        end
        FILL: begin
          if (done_q) begin
            done_q   <= 1'b0;
            i_ack_q  <= ~sel_d_q;
            d_ack_q  <= sel_d_q;
            clk_en_q <= 1'b1;
            if (BUBBLE_CYCLES == 0) begin
              state_q <= IDLE;
            end else begin
              state_q  <= BUBBLE;
              bubble_q <= 1'b1;
              bcnt_q   <= BC_W'(BUBBLE_CYCLES - 1);
            end
          end else if (fire) begin
            i_we_q  <= ~sel_d_q;
            d_we_q  <= sel_d_q;
            raddr_q <= spi_addr_q;
            rdata_q <= spi_fetch;
            wcnt_q  <= wcnt_nxt;
            if (last) begin
              done_q  <= 1'b1;
              valid_q <= 1'b0;
            end else begin
              spi_addr_q <= word_addr(miss_base_q, wcnt_nxt);
            end
          end
        end
        BUBBLE: begin
          if (bcnt_q == '0) begin
            state_q  <= IDLE;
            bubble_q <= 1'b0;
          end else begin
            bcnt_q <= bcnt_q - BC_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign victim_idx     = wcnt_q;
  assign spi_store      = (state_q == WB) ? d_victim_data : '0;
  assign spi_address    = spi_addr_q;
  assign write_strobe   = wstrb_q;
  assign spi_addr_valid = valid_q;
  assign i_refill_we    = i_we_q;
  assign d_refill_we    = d_we_q;
  assign refill_addr    = raddr_q;
  assign refill_data    = rdata_q;
  assign i_miss_ack     = i_ack_q;
  assign d_miss_ack     = d_ack_q;
  assign set_clk_enable = clk_en_q;
  assign core_bubble    = bubble_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_cache_refill_ctrl_v2.sv
// tb_cache_refill_ctrl_v2: random I/D miss traffic against a line-level
// reference model, plus reset abort and an 8-word no-bubble instance.
`timescale 1ns/1ps
module tb_cache_refill_ctrl_v2;
  localparam int LW      = 4;
  localparam int BUB     = 5;
  localparam int D_FIRST = 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          wr;
  } spi_t;

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    logic [31:0] data;
  } ref_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_miss_req, d_miss_req, d_victim_dirty;
  logic [31:0] i_miss_addr, d_miss_addr, d_victim_addr, d_victim_data;
  logic [1:0]  victim_idx;
  logic        i_refill_we, d_refill_we, i_miss_ack, d_miss_ack;
  logic [31:0] refill_addr, refill_data, spi_address, spi_store;
  logic [3:0]  write_strobe;
  logic        spi_addr_valid, spi_ready;
  logic [31:0] spi_fetch;
  logic        set_clk_enable, core_bubble, busy;

  logic        b_i_req, b_d_req;
  logic [31:0] b_i_addr;
  logic [2:0]  b_vidx;
  logic        b_i_we, b_d_we, b_i_ack, b_d_ack;
  logic [31:0] b_raddr, b_rdata, b_spi_addr, b_spi_store;
  logic [3:0]  b_wstrb;
  logic        b_valid, b_ready;
  logic [31:0] b_fetch;
  logic        b_clk_en, b_bubble, b_busy;

  logic [31:0] vic_mem [LW];
  spi_t        spi_q[$];
  ref_t        ref_q[$];
  bit          ack_q[$];
  bit          zero_wait, stray_en, in_word;
  int          wait_left;
  int          checks, failures;

  always #5 clk = ~clk;

  assign d_victim_data = vic_mem[victim_idx];

  cache_refill_ctrl_v2 #(
    .ADDR_W(32), .DATA_W(32), .LINE_WORDS(LW),
    .D_FIRST(D_FIRST), .BUBBLE_CYCLES(BUB)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss_req(i_miss_req), .i_miss_addr(i_miss_addr),
    .d_miss_req(d_miss_req), .d_miss_addr(d_miss_addr),
    .d_victim_dirty(d_victim_dirty), .d_victim_addr(d_victim_addr),
    .d_victim_data(d_victim_data), .victim_idx(victim_idx),
    .i_refill_we(i_refill_we), .d_refill_we(d_refill_we),
    .refill_addr(refill_addr), .refill_data(refill_data),
    .i_miss_ack(i_miss_ack), .d_miss_ack(d_miss_ack),
    .spi_address(spi_address), .spi_store(spi_store),
    .write_strobe(write_strobe), .spi_addr_valid(spi_addr_valid),
    .spi_ready(spi_ready), .spi_fetch(spi_fetch),
    .set_clk_enable(set_clk_enable), .core_bubble(core_bubble),
    .busy(busy)
  );

  cache_refill_ctrl_v2 #(
    .ADDR_W(32), .DATA_W(32), .LINE_WORDS(8),
    .D_FIRST(1), .BUBBLE_CYCLES(0)
  ) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .i_miss_req(b_i_req), .i_miss_addr(b_i_addr),
    .d_miss_req(b_d_req), .d_miss_addr(32'h0),
    .d_victim_dirty(1'b0), .d_victim_addr(32'h0),
    .d_victim_data(32'h0), .victim_idx(b_vidx),
    .i_refill_we(b_i_we), .d_refill_we(b_d_we),
    .refill_addr(b_raddr), .refill_data(b_rdata),
    .i_miss_ack(b_i_ack), .d_miss_ack(b_d_ack),
    .spi_address(b_spi_addr), .spi_store(b_spi_store),
    .write_strobe(b_wstrb), .spi_addr_valid(b_valid),
    .spi_ready(b_ready), .spi_fetch(b_fetch),
    .set_clk_enable(b_clk_en), .core_bubble(b_bubble),
    .busy(b_busy)
  );

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Line-level model: the SPI words and array writes one service implies.
  task automatic push_line(input bit is_d, input bit dirty,
                           input logic [31:0] a, input logic [31:0] v);
    logic [31:0] base, vb;
    spi_t s;
    ref_t r;
    base = a & ~32'(LW * 4 - 1);
    vb   = v & ~32'(LW * 4 - 1);
    if (dirty) begin
      for (int k = 0; k < LW; k++) begin
        s.addr = vb + 32'(4 * k);
        s.data = vic_mem[k];
        s.wr   = 1'b1;
        spi_q.push_back(s);
      end
    end
    for (int k = 0; k < LW; k++) begin
      s.addr = base + 32'(4 * k);
      s.data = 32'h0;
      s.wr   = 1'b0;
      spi_q.push_back(s);
      r.is_d = is_d;
      r.addr = s.addr;
      r.data = memfn(s.addr);
      ref_q.push_back(r);
    end
    ack_q.push_back(is_d);
  endtask

  // SPI slave with random wait states, plus refill and clock-gate monitor.
  initial begin : slave_mon
    ref_t r;
    spi_t s;
    spi_ready = 1'b0;
    spi_fetch = 32'h0;
    in_word   = 1'b0;
    wait_left = 0;
    forever begin
      @(posedge clk);
      #1;
      spi_ready = 1'b0;
      if (!rst_n) begin
        spi_q.delete();
        ref_q.delete();
        in_word = 1'b0;
      end else begin
        chk("clk_en", 64'(set_clk_enable), 64'(!(busy && !core_bubble)));
        if (i_refill_we || d_refill_we) begin
          if (ref_q.size() == 0) begin
            chk("ref_unexp", 64'(1), 64'(0));
          end else begin
            r = ref_q.pop_front();
            chk("ref_sel", 64'({i_refill_we, d_refill_we}),
                64'(r.is_d ? 2'b01 : 2'b10));
            chk("ref_addr", 64'(refill_addr), 64'(r.addr));
            chk("ref_data", 64'(refill_data), 64'(r.data));
          end
        end
        if (spi_addr_valid) begin
          if (!in_word) begin
            in_word   = 1'b1;
            wait_left = zero_wait ? 0 : int'($urandom_range(0, 7));
          end
          if (spi_q.size() == 0) begin
            chk("spi_unexp", 64'(1), 64'(0));
          end else begin
            s = spi_q[0];
            chk("spi_addr", 64'(spi_address), 64'(s.addr));
            chk("spi_strb", 64'(write_strobe), 64'(s.wr ? 4'hF : 4'h0));
            if (s.wr) chk("spi_store", 64'(spi_store), 64'(s.data));
          end
          if (wait_left == 0) begin
            if (spi_q.size() != 0) spi_q.delete(0);
            spi_ready = 1'b1;
            spi_fetch = memfn(spi_address);
            in_word   = 1'b0;
          end else begin
            wait_left--;
          end
        end else begin
          in_word = 1'b0;
          if (stray_en && $urandom_range(0, 3) == 0) begin
            spi_ready = 1'b1;
            spi_fetch = $urandom;
          end
        end
      end
    end
  end

  task automatic chk_rst(input string tag);
    chk({tag, "_ctl"},
        64'({i_refill_we, d_refill_we, i_miss_ack, d_miss_ack,
             spi_addr_valid, set_clk_enable, core_bubble, busy}),
        64'(8'b0000_0100));
    chk({tag, "_spi"}, {spi_address, spi_store}, 64'h0);
    chk({tag, "_ref"}, {refill_addr, refill_data}, 64'h0);
    chk({tag, "_idx"}, 64'({victim_idx, write_strobe}), 64'h0);
  endtask

  task automatic run_scn(input bit do_i, input bit do_d, input bit dirty,
                         input bit zw, input logic [31:0] ia,
                         input logic [31:0] da, input logic [31:0] va);
    int n, bub, nacks, exp_lat;
    bit is_d;
    zero_wait = zw;
    stray_en  = !zw;
    for (int k = 0; k < LW; k++) vic_mem[k] = $urandom;
    i_miss_addr    = ia;
    d_miss_addr    = da;
    d_victim_addr  = va;
    d_victim_dirty = dirty;
    if (do_d && (D_FIRST != 0 || !do_i)) begin
      push_line(1'b1, dirty, da, va);
      if (do_i) push_line(1'b0, 1'b0, ia, va);
    end else begin
      push_line(1'b0, 1'b0, ia, va);
      if (do_d) push_line(1'b1, dirty, da, va);
    end
    i_miss_req = do_i;
    d_miss_req = do_d;
    n = 0; bub = 0; nacks = 0; exp_lat = 0;
    while ((ack_q.size() != 0 || busy) && n < 600) begin
      @(posedge clk);
      #1;
      n++;
      if (core_bubble) begin
        bub++;
      end else if (bub != 0) begin
        chk("bubble_len", 64'(bub), 64'(BUB));
        bub = 0;
      end
      if (i_miss_ack || d_miss_ack) begin
        if (ack_q.size() == 0) begin
          chk("ack_unexp", 64'(1), 64'(0));
        end else begin
          is_d = ack_q.pop_front();
          chk("ack_sel", 64'({i_miss_ack, d_miss_ack}),
              64'(is_d ? 2'b01 : 2'b10));
          exp_lat += LW + 2 + ((is_d && dirty) ? LW : 0)
                   + ((nacks != 0) ? BUB : 0);
          if (zw) chk("latency", 64'(n), 64'(exp_lat));
          chk("ack_bubble", 64'(core_bubble), 64'(1));
          nacks++;
        end
        if (i_miss_ack) i_miss_req = 1'b0;
        if (d_miss_ack) d_miss_req = 1'b0;
      end
    end
    if (n >= 600) chk("timeout", 64'(1), 64'(0));
    chk("spi_left", 64'(spi_q.size()), 64'(0));
    chk("ref_left", 64'(ref_q.size()), 64'(0));
    i_miss_req = 1'b0;
    d_miss_req = 1'b0;
    ack_q.delete();
  endtask

  task automatic rst_scn();
    int cnt, n;
    zero_wait = $urandom_range(0, 1);
    stray_en  = 1'b0;
    for (int k = 0; k < LW; k++) vic_mem[k] = $urandom;
    d_miss_addr    = $urandom;
    d_victim_dirty = 1'b0;
    push_line(1'b1, 1'b0, d_miss_addr, 32'h0);
    d_miss_req = 1'b1;
    cnt = 0; n = 0;
    while (cnt < 2 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (d_refill_we) cnt++;
    end
    chk("rst_reach", 64'(cnt), 64'(2));
    #1 rst_n = 1'b0;
    #1 chk_rst("midrst");
    d_miss_req = 1'b0;
    ack_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 chk("rst_noack", 64'({i_miss_ack, d_miss_ack, busy}), 64'(0));
    end
  endtask

  // 8-word line, no bubble state, zero-wait SPI.
  task automatic run_b();
    int n, j, k;
    bit acked, bub_seen;
    b_i_addr = 32'h0000_00FC;
    b_i_req  = 1'b1;
    n = 0; j = 0; k = 0; acked = 1'b0; bub_seen = 1'b0;
    while (!acked && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      b_ready = 1'b0;
      if (b_bubble) bub_seen = 1'b1;
      if (b_i_we) begin
        chk("b_raddr", 64'(b_raddr), 64'(32'hE0 + 32'(4 * k)));
        chk("b_rdata", 64'(b_rdata), 64'(memfn(32'hE0 + 32'(4 * k))));
        k++;
      end
      if (b_valid) begin
        chk("b_spi_addr", 64'(b_spi_addr), 64'(32'hE0 + 32'(4 * j)));
        j++;
        b_ready = 1'b1;
        b_fetch = memfn(b_spi_addr);
      end
      if (b_i_ack) begin
        acked = 1'b1;
        chk("b_latency", 64'(n), 64'(10));
        chk("b_idle", 64'({b_busy, b_clk_en}), 64'(2'b01));
        b_i_req = 1'b0;
      end
    end
    chk("b_acked", 64'(acked), 64'(1));
    chk("b_words", 64'(k), 64'(8));
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      if (b_bubble) bub_seen = 1'b1;
      chk("b_stay_idle", 64'({b_busy, b_d_we, b_i_we}), 64'(0));
    end
    chk("b_no_bubble", 64'(bub_seen), 64'(0));
  endtask

  initial begin : main
    checks = 0; failures = 0;
    rst_n = 1'b0;
    i_miss_req = 1'b0; d_miss_req = 1'b0; d_victim_dirty = 1'b0;
    i_miss_addr = 32'h0; d_miss_addr = 32'h0; d_victim_addr = 32'h0;
    zero_wait = 1'b1; stray_en = 1'b0;
    for (int k = 0; k < LW; k++) vic_mem[k] = 32'h0;
    b_i_req = 1'b0; b_d_req = 1'b0; b_i_addr = 32'h0;
    b_ready = 1'b0; b_fetch = 32'h0;
    repeat (3) @(posedge clk);
    #1 chk_rst("reset");
    chk("b_reset", 64'({b_clk_en, b_busy, b_valid}), 64'(3'b100));
    @(posedge clk);
    #3 rst_n = 1'b1;
    run_scn(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_1234, 32'h0);
    run_scn(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0000_1230, 32'h0000_2000);
    run_scn(1'b1, 1'b1, 1'b0, 1'b1, 32'h4000_0018, 32'h0000_8024, 32'h0);
    run_scn(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0A00, 32'h0000_0B0C,
            32'h0000_0C04);
    for (int t = 0; t < 24; t++) begin
      int kind;
      kind = $urandom_range(0, 2);
      run_scn(kind != 1, kind != 0, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);
    end
    rst_scn();
    run_scn(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_1234, 32'h0);
    run_b();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
